// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial WIDTH-bit subtractor that reuses a single
// Full_Subtractor cell. Bits are processed LSB first, and the borrow is chained
// through a register between bits.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.

// One-bit full subtractor cell (purely combinational).
module Full_Subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borrow
);
  // diff = a - b - cin (mod 2); borrow when a < b + cin
  assign diff   = a ^ b ^ cin;
  assign borrow = (~a & b) | (~(a ^ b) & cin);
endmodule

module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned RES_W = WIDTH - 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // Holds the WIDTH-1 low difference bits; the last bit comes straight from the cell.
  logic [RES_W-1:0]   res_sr_q, res_sr_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_out_q, diff_out_d;
  logic               borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic cell_diff;
  logic cell_borrow;

  // The single shared subtractor cell, fed from the operand LSBs and the borrow register.
  Full_Subtractor u_cell (
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .cin    (brw_q),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_sr_d     = res_sr_q;
    brw_d        = brw_q;
    cnt_d        = cnt_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    diff_out_d   = diff_out_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d        = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = RES_W'({cell_diff, res_sr_q} >> 1);
        brw_d    = cell_borrow;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: the cell output completes the word this edge.
          state_d      = DONE;
          done_d       = 1'b1;
          diff_out_d   = {cell_diff, res_sr_q};
          borrow_out_d = cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
          // Shift regs hold the operand MSBs now; cell_diff is the result MSB.
          ovf_d        = (a_sr_q[0] != b_sr_q[0]) && (cell_diff != a_sr_q[0]);
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_sr_q     <= '0;
      brw_q        <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_out_q   <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_sr_q     <= res_sr_d;
      brw_q        <= brw_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_out_q   <= diff_out_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff_out   = diff_out_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: an 8-bit instance for directed
// and timing checks, and a 4-bit instance for an exhaustive sweep. Results are
// scoreboarded: expectations are queued at start and popped on each done pulse.
module tb_serial_subtractor_ctrl;

  typedef struct {
    logic [7:0] d;
    logic       b;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;
  logic       ovf8;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;
  logic       ovf4;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t q8[$];
  exp_t q4[$];
  logic prev_done8 = 1'b0;
  int   done8_seen = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff_out(diff8),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf8),
`endif
    .borrow_out(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff_out(diff4),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf4),
`endif
    .borrow_out(bo4)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: difference from wide arithmetic, borrow from an unsigned compare.
  function automatic exp_t model(input int unsigned w, input logic [7:0] a,
                                 input logic [7:0] b, input logic bi);
    exp_t       e;
    logic [8:0] full;
    logic [7:0] mask;
    mask = 8'((9'd1 << w) - 9'd1);
    full = {1'b0, a} - {1'b0, b} - 9'(bi);
    e.d  = full[7:0] & mask;
    e.b  = ({1'b0, a} < ({1'b0, b} + 9'(bi)));
    e.o  = (a[w-1] != b[w-1]) && (e.d[w-1] != a[w-1]);
    return e;
  endfunction

  // Scoreboard monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst && done8) begin
      done8_seen++;
      check("done8_pulse_width", 32'(prev_done8), 32'(0));
      if (q8.size() == 0) begin
        check("sb8_unexpected_done", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("sb8_diff", 32'(diff8), 32'(e.d));
        check("sb8_borrow", 32'(bo8), 32'(e.b));
`ifdef SERIAL_SUB_OVF_EN
        check("sb8_ovf", 32'(ovf8), 32'(e.o));
`endif
      end
    end
    prev_done8 <= done8;
  end

  // Scoreboard monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("sb4_unexpected_done", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("sb4_diff", 32'(diff4), 32'(e.d));
        check("sb4_borrow", 32'(bo4), 32'(e.b));
`ifdef SERIAL_SUB_OVF_EN
        check("sb4_ovf", 32'(ovf4), 32'(e.o));
`endif
      end
    end
  end

  // Drives start for one edge (E0); returns #1 after E0.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input bit push);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    bin8 = bi;
    if (push) q8.push_back(model(8, a, b, bi));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    bin8 = 1'($urandom);
  endtask

  // From #1 after E0, counts edges until done is seen and busy cycles on the way.
  task automatic wait_done8(input bit poke, output int n, output int bc);
    n = 0;
    bc = 0;
    while (!done8 && n < 40) begin
      if (busy8) bc++;
      @(posedge clk);
      #1;
      n++;
      if (poke) begin
        start8 = (n == 3);
        if (n == 3) begin
          a8 = 8'hFF;
          b8 = 8'h00;
          bin8 = 1'b1;
        end
      end
    end
    start8 = 1'b0;
  endtask

  // One isolated 8-bit operation with latency, busy and hold checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input bit poke);
    int   n, bc;
    exp_t e;
    e = model(8, a, b, bi);
    @(negedge clk);
    launch8(a, b, bi, 1'b1);
    wait_done8(poke, n, bc);
    // done rises on edge E0+WIDTH, so it is visible in the cycle after that edge.
    check("done_latency", 32'(n), 32'(8));
    check("busy_cycles", 32'(bc), 32'(8));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done8), 32'(0));
    check("hold_diff", 32'(diff8), 32'(e.d));
    check("hold_borrow", 32'(bo8), 32'(e.b));
  endtask

  initial begin
    int   n, bc, seen_before;
    exp_t e1;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'(0));
    check("rst_done", 32'(done8), 32'(0));
    check("rst_diff", 32'(diff8), 32'(0));
    check("rst_borrow", 32'(bo8), 32'(0));
    check("rst_ovf", 32'(ovf8), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed operations.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    op8(8'h00, 8'h01, 1'b0, 1'b0);
    op8(8'h10, 8'h0F, 1'b1, 1'b0);
    // A start pulse during RUN must be ignored.
    op8(8'h33, 8'h11, 1'b0, 1'b1);

    // Back-to-back: start accepted in the DONE cycle.
    e1 = model(8, 8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    launch8(8'h5A, 8'h3C, 1'b0, 1'b1);
    wait_done8(1'b0, n, bc);
    check("b2b_first_done", 32'(done8), 32'(1));
    launch8(8'h80, 8'h01, 1'b0, 1'b1);
    check("b2b_busy_no_gap", 32'(busy8), 32'(1));
    check("b2b_done_low", 32'(done8), 32'(0));
    check("b2b_diff_held", 32'(diff8), 32'(e1.d));
    wait_done8(1'b0, n, bc);
    check("b2b_latency", 32'(n), 32'(8));
    @(posedge clk);
    #1;

    op8(8'h7F, 8'hFF, 1'b0, 1'b0);
    op8(8'h05, 8'h03, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN cycle 4.
    @(negedge clk);
    launch8(8'hC3, 8'h21, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", 32'(busy8), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_diff", 32'(diff8), 32'(0));
    check("async_rst_borrow", 32'(bo8), 32'(0));
    check("async_rst_busy", 32'(busy8), 32'(0));
    check("async_rst_done", 32'(done8), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_before = done8_seen;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", 32'(done8_seen - seen_before), 32'(0));
    check("idle_after_rst", 32'(busy8), 32'(0));
    op8(8'hFF, 8'hFF, 1'b0, 1'b0);

    // A few random operations.
    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    // Exhaustive 4-bit sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          int k;
          @(negedge clk);
          start4 = 1'b1;
          a4 = 4'(a);
          b4 = 4'(b);
          bin4 = 1'(bi);
          q4.push_back(model(4, 8'(a), 8'(b), 1'(bi)));
          @(posedge clk);
          #1;
          start4 = 1'b0;
          k = 0;
          while (!done4 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
          end
          if (k >= 20) check("sweep4_timeout", 32'(k), 32'(4));
        end
      end
    end

    repeat (3) @(negedge clk);
    check("sb8_drained", 32'(q8.size()), 32'(0));
    check("sb4_drained", 32'(q4.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
